// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
package calc_pkg;

    localparam int CALC_N = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FIN
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide datapath with its iteration counter.
// hi/lo form one 2N-bit accumulator: product high/low for MUL, partial remainder/quotient for DIV.
module muldiv_iter
    import calc_pkg::*;
#(
    parameter int N = CALC_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         last_o,
    output logic [N-1:0] hi_nxt_o,
    output logic [N-1:0] lo_nxt_o
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt_q;
    logic [N-1:0]  hi_q, lo_q;
    logic [N-1:0]  hi_d, lo_d;
    logic [N:0]    madd, shifted, trial;

    always_comb begin
        madd    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_i} : '0);
        shifted = {hi_q, lo_q[N-1]};
        trial   = shifted - {1'b0, b_i};
        hi_d    = madd[N:1];
        lo_d    = {madd[0], lo_q[N-1:1]};
        if (div_i) begin
            // Restoring step: keep the subtraction only when it does not go negative.
            if (shifted >= {1'b0, b_i}) begin
                hi_d = trial[N-1:0];
                lo_d = {lo_q[N-2:0], 1'b1};
            end else begin
                hi_d = shifted[N-1:0];
                lo_d = {lo_q[N-2:0], 1'b0};
            end
        end
    end

    assign last_o   = (cnt_q == '0);
    assign hi_nxt_o = hi_d;
    assign lo_nxt_o = lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(N - 1);
        end else if (step_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            hi_q <= '0;
            lo_q <= a_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer with a single DONE/RES_CE strobe per operation.
// Define CALC_REMAINDER_EN to expose the division remainder on REM.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int N = CALC_N
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic [1:0]   OP,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic         RES_CE,
    output logic [N-1:0] RESULT,
`ifdef CALC_REMAINDER_EN
    output logic [N-1:0] REM,
`endif
    output logic         OVF,
    output logic         DIVZ
);

    state_e       state_q, state_d;
    op_e          op_q;
    logic [N-1:0] a_q, b_q;
    logic         load, step, fin_en, last, divz_case;
    logic [N-1:0] hi_nxt, lo_nxt;
    logic [N:0]   sum, diff;
    logic [N-1:0] res_q, res_d;
    logic         ovf_q, ovf_d, divz_q, divz_d, done_q;
`ifdef CALC_REMAINDER_EN
    logic [N-1:0] rem_q, rem_d;
`endif

    muldiv_iter #(.N(N)) u_iter (
        .clk      (CLK),
        .rst      (CLR),
        .load_i   (load),
        .step_i   (step),
        .div_i    (op_q == OP_DIV),
        .a_i      (A),
        .b_i      (b_q),
        .last_o   (last),
        .hi_nxt_o (hi_nxt),
        .lo_nxt_o (lo_nxt)
    );

    assign divz_case = (op_q == OP_DIV) && (b_q == '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    load    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_ADD || op_q == OP_SUB || divz_case) begin
                    state_d = S_FIN;
                end else begin
                    step = 1'b1;
                    if (last) state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        fin_en = (state_q == S_EXEC) && (state_d == S_FIN);
    end

    // Completion values; for MUL/DIV they come from the final iteration step.
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        res_d  = lo_nxt;
        ovf_d  = 1'b0;
        divz_d = 1'b0;
`ifdef CALC_REMAINDER_EN
        rem_d  = '0;
`endif
        case (op_q)
            OP_ADD: begin
                res_d = sum[N-1:0];
                ovf_d = sum[N];
            end
            OP_SUB: begin
                res_d = diff[N-1:0];
                ovf_d = diff[N];
            end
            OP_MUL: ovf_d = |hi_nxt;
            default: begin
                if (divz_case) begin
                    res_d  = '1;
                    divz_d = 1'b1;
`ifdef CALC_REMAINDER_EN
                    rem_d  = a_q;
`endif
                end else begin
`ifdef CALC_REMAINDER_EN
                    rem_d  = hi_nxt;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            divz_q  <= 1'b0;
`ifdef CALC_REMAINDER_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= fin_en;
            if (fin_en) begin
                res_q  <= res_d;
                ovf_q  <= ovf_d;
                divz_q <= divz_d;
`ifdef CALC_REMAINDER_EN
                rem_q  <= rem_d;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (load) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_e'(OP);
        end
    end

    assign BUSY   = (state_q == S_EXEC);
    assign DONE   = done_q;
    assign RES_CE = done_q;
    assign RESULT = res_q;
    assign OVF    = ovf_q;
    assign DIVZ   = divz_q;
`ifdef CALC_REMAINDER_EN
    assign REM    = rem_q;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: directed table, random ops against a model, corner sequences.
module tb_calc_op_sequencer;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         CLR, START;
    logic [1:0]   OP;
    logic [N-1:0] A, B;
    logic         BUSY, DONE, RES_CE, OVF, DIVZ;
    logic [N-1:0] RESULT;
`ifdef CALC_REMAINDER_EN
    logic [N-1:0] REM;
`endif

    int total = 0;
    int bad   = 0;

    calc_op_sequencer #(.N(N)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .START  (START),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RES_CE (RES_CE),
        .RESULT (RESULT),
`ifdef CALC_REMAINDER_EN
        .REM    (REM),
`endif
        .OVF    (OVF),
        .DIVZ   (DIVZ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] op;
        int         a, b;
        int         res, rem, ovf, divz, lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; lat counts edges after the START edge until DONE shows.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int rem, output int ovf,
                         output int divz, output int lat);
        int t;
        rem = 0; ovf = 0; divz = 0; lat = 1;
        case (op)
            0: begin t = a + b; res = t % 256; ovf = (t > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; ovf = (a < b) ? 1 : 0; end
            2: begin t = a * b; res = t % 256; ovf = (t > 255) ? 1 : 0; lat = N; end
            default: begin
                if (b == 0) begin
                    res = 255; rem = a; divz = 1;
                end else begin
                    res = a / b; rem = a % b; lat = N;
                end
            end
        endcase
    endtask

    // Issues one START and waits (bounded) for DONE; lat = -1 on timeout.
    task automatic run_op(input logic [1:0] op, input int a, input int b, output int lat);
        @(negedge CLK);
        START = 1'b1; OP = op; A = a[N-1:0]; B = b[N-1:0];
        @(posedge CLK); #1;
        START = 1'b0;
        OP = 2'($urandom); A = N'($urandom); B = N'($urandom);
        check("busy_after_start", int'(BUSY), 1);
        lat = -1;
        for (int i = 1; i <= 4 * N; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int res,
                                input int rem, input int ovf, input int divz, input int elat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_res"}, int'(RESULT), res);
        check({tag, "_ovf"}, int'(OVF), ovf);
        check({tag, "_divz"}, int'(DIVZ), divz);
        check({tag, "_resce"}, int'(RES_CE), int'(DONE));
        check({tag, "_busy_fin"}, int'(BUSY), 0);
`ifdef CALC_REMAINDER_EN
        check({tag, "_rem"}, int'(REM), rem);
`endif
        @(posedge CLK); #1;
        check({tag, "_done_once"}, int'(DONE), 0);
        check({tag, "_hold_res"}, int'(RESULT), res);
    endtask

    vec_t vecs[8];
    int lat, res, rem, ovf, divz, elat, a, b, op, dones;

    initial begin
        CLR = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_resce", int'(RES_CE), 0);
        check("rst_result", int'(RESULT), 0);
        check("rst_ovf", int'(OVF), 0);
        check("rst_divz", int'(DIVZ), 0);
        CLR = 1'b0;

        vecs[0] = '{op: 2'd0, a: 200, b: 100, res: 8'h2C, rem: 0, ovf: 1, divz: 0, lat: 1};
        vecs[1] = '{op: 2'd1, a: 5,   b: 9,   res: 8'hFC, rem: 0, ovf: 1, divz: 0, lat: 1};
        vecs[2] = '{op: 2'd1, a: 9,   b: 5,   res: 4,     rem: 0, ovf: 0, divz: 0, lat: 1};
        vecs[3] = '{op: 2'd2, a: 15,  b: 17,  res: 8'hFF, rem: 0, ovf: 0, divz: 0, lat: N};
        vecs[4] = '{op: 2'd2, a: 16,  b: 16,  res: 0,     rem: 0, ovf: 1, divz: 0, lat: N};
        vecs[5] = '{op: 2'd3, a: 200, b: 7,   res: 28,    rem: 4, ovf: 0, divz: 0, lat: N};
        vecs[6] = '{op: 2'd3, a: 9,   b: 0,   res: 8'hFF, rem: 9, ovf: 0, divz: 1, lat: 1};
        vecs[7] = '{op: 2'd0, a: 255, b: 1,   res: 0,     rem: 0, ovf: 1, divz: 0, lat: 1};

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check_result($sformatf("vec%0d", i), lat, vecs[i].res, vecs[i].rem,
                         vecs[i].ovf, vecs[i].divz, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            model(op, a, b, res, rem, ovf, divz, elat);
            run_op(2'(op), a, b, lat);
            check_result($sformatf("rnd%0d_op%0d_%0d_%0d", i, op, a, b), lat, res, rem, ovf, divz, elat);
        end

        // START pulsed during a MUL must be dropped.
        @(negedge CLK);
        START = 1'b1; OP = 2'd2; A = 3; B = 4;
        @(posedge CLK); #1;
        START = 1'b0;
        dones = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge CLK);
            if (i == 1 || i == 2) begin
                START = 1'b1; OP = 2'd0; A = 100; B = 50;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        check("busy_drop_dones", dones, 1);
        check("busy_drop_res", int'(RESULT), 12);
        check("busy_drop_idle", int'(BUSY), 0);

        // CLR in the third EXEC cycle of a MUL aborts it without DONE.
        @(negedge CLK);
        START = 1'b1; OP = 2'd2; A = 200; B = 3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        check("clr_busy", int'(BUSY), 0);
        check("clr_done", int'(DONE), 0);
        check("clr_result", int'(RESULT), 0);
        check("clr_ovf", int'(OVF), 0);
        check("clr_divz", int'(DIVZ), 0);
`ifdef CALC_REMAINDER_EN
        check("clr_rem", int'(REM), 0);
`endif
        dones = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        check("clr_no_done", dones, 0);
        run_op(2'd0, 1, 1, lat);
        check_result("post_clr_add", lat, 2, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
